register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning register count (power of two, >=4).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(NUM_REGS), meaning register index width.
REQ-004 The block SHALL have parameter NUM_RD, default 2, meaning read-port count (1..4).
REQ-005 The block SHALL have parameter ZERO_REG_EN, default 1, meaning register 0 is hardwired to zero when 1.
REQ-006 The block SHALL have parameter BYPASS_EN, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-007 The block SHALL have parameter CNT_WIDTH, default 16, meaning write-activity counter width.
REQ-008 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-009 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-010 The block SHALL have port rd_addr  input  NUM_RD*ADDR_WIDTH  packed read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 The block SHALL have port rd_data  output  NUM_RD*DATA_WIDTH  packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have ports wr_en0/wr_en1  input  1 each  write enables for write ports 0 and 1.
REQ-013 The block SHALL have ports wr_addr0/wr_addr1  input  ADDR_WIDTH each  write indices.
REQ-014 The block SHALL have ports wr_data0/wr_data1  input  DATA_WIDTH each  write data.
REQ-015 The block SHALL have port clr_req  input  1  one-cycle request to start a sequential clear.
REQ-016 The block SHALL have port clr_busy  output  1  high while a clear is in progress.
REQ-017 The block SHALL have port wr_count  output  CNT_WIDTH  saturating count of accepted register writes.
REQ-018 The block SHALL have port debug  output  16  register NUM_REGS-1 bits [15:0].

Function
REQ-019 Reads SHALL be combinational: rd_data port k = RF[rd_addr k], zero-cycle latency.
REQ-020 With ZERO_REG_EN=1, reads of index 0 SHALL return 0, and writes to index 0 SHALL be discarded and not counted.
REQ-021 A write SHALL be accepted when wr_enN=1, clr_busy=0, and the index is not a discarded zero-register write; RF is updated at the next rising edge.
REQ-022 When both ports write the same index in one cycle, port 1 data SHALL win, and the counter SHALL count 1 write.
REQ-023 With BYPASS_EN=1 and clr_busy=0, a read whose index matches an accepted write this cycle SHALL return that write data (port 1 over port 0); index 0 with ZERO_REG_EN=1 still returns 0.
REQ-024 With BYPASS_EN=0, reads SHALL return pre-edge RF contents.
REQ-025 The clear FSM SHALL have states IDLE and CLEAR, where IDLE goes to CLEAR on clr_req=1.
REQ-026 In CLEAR, the FSM SHALL zero index clr_idx each cycle (starting at 0, incrementing by 1), then return to IDLE after index NUM_REGS-1; CLEAR lasts exactly NUM_REGS cycles.
REQ-027 clr_busy SHALL be 1 exactly while in CLEAR (registered, rises the cycle after clr_req).
REQ-028 clr_req SHALL be ignored while in CLEAR, and writes SHALL be dropped (not counted) while in CLEAR.
REQ-029 A write accepted in the same cycle clr_req is sampled in IDLE SHALL complete and SHALL then be zeroed by the clear.
REQ-030 Reads during CLEAR SHALL return current RF contents, with no bypass.
REQ-031 wr_count SHALL add the accepted distinct writes per cycle (0, 1 or 2), SHALL saturate at 2^CNT_WIDTH-1 with no wrap, and SHALL reset to 0 on the IDLE-to-CLEAR transition.
REQ-032 debug SHALL equal RF[NUM_REGS-1][15:0], combinational.

Reset
REQ-033 When rst=0, the block SHALL asynchronously zero all RF entries, set the FSM to IDLE, set clr_idx=0, clr_busy=0 and wr_count=0; all rd_data and debug SHALL read 0.
REQ-034 Reset asserted mid-CLEAR SHALL abort the clear immediately; after release the FSM SHALL be in IDLE.
REQ-035 The block SHALL leave reset on the first rising edge after rst=1, with no writes accepted while rst=0.

Verification
REQ-036 The bench SHALL cover basic write/read: wr_en0=1, addr 5, data 0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF, wr_count=1.
REQ-037 The bench SHALL cover collision: both ports write addr 7 (0x11, 0x22) in one cycle -> RF[7]=0x22, wr_count increments by 1; distinct addrs 3 and 4 -> +2.
REQ-038 The bench SHALL cover bypass: write addr 9 = 0xA5A5A5A5 with rd_addr1=9 in the same cycle -> rd_data1=0xA5A5A5A5 before the edge; with BYPASS_EN=0 -> old value.
REQ-039 The bench SHALL cover the zero register: write addr 0 = 0xFFFFFFFF -> reads of addr 0 return 0, wr_count unchanged.
REQ-040 The bench SHALL cover clear: fill all registers, pulse clr_req -> clr_busy high for 32 cycles, a write issued mid-clear is dropped, then all reads are 0 and wr_count=0.
REQ-041 The bench SHALL cover counter saturation and reset mid-clear: with CNT_WIDTH=4, 20 writes -> wr_count=15; rst=0 at clear cycle 10 -> clr_busy=0 immediately and all registers 0.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports,
// optional hardwired zero register, optional write-to-read forwarding,
// a sequential clear engine and a saturating write-activity counter.
//
// Handshake: there is no valid/ready pair. A write is accepted when its
// wr_enN is high, the clear engine is idle (clr_busy=0), reset is released,
// and the index is not a discarded zero-register write. clr_req is a one-cycle
// request that is only honoured while idle.
module register_file_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wr_en0,
  input  logic                         wr_en1,
  input  logic [ADDR_WIDTH-1:0]        wr_addr0,
  input  logic [ADDR_WIDTH-1:0]        wr_addr1,
  input  logic [DATA_WIDTH-1:0]        wr_data0,
  input  logic [DATA_WIDTH-1:0]        wr_data1,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic [CNT_WIDTH-1:0]         wr_count,
  output logic [15:0]                  debug
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // state_q is the clear engine's state; it is visible to checkers by name.
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0]   rf [NUM_REGS];
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic                    in_idle;
  logic                    clr_start;
  logic                    zero0, zero1;
  logic                    acc0, acc1;
  logic [1:0]              wr_inc;
  logic [CNT_WIDTH:0]      cnt_sum;

  // Write acceptance: only while out of reset and not clearing.
  always_comb begin
    in_idle   = rst && (state_q == IDLE);
    clr_start = in_idle && clr_req;
    zero0     = (ZERO_REG_EN != 0) && (wr_addr0 == '0);
    zero1     = (ZERO_REG_EN != 0) && (wr_addr1 == '0);
    acc0      = wr_en0 && in_idle && !zero0;
    acc1      = wr_en1 && in_idle && !zero1;
    // A same-index collision is one register update, so it counts once.
    if (acc0 && acc1 && (wr_addr0 == wr_addr1)) begin
      wr_inc = 2'd1;
    end else begin
      wr_inc = {1'b0, acc0} + {1'b0, acc1};
    end
    cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(wr_inc);
  end

  // Clear FSM next-state: walk every index once, then fall back to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign clr_busy = (state_q == CLEAR);

  // Register array: clear engine has priority; port 1 wins a collision by order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      rf[clr_idx_q] <= '0;
    end else begin
      if (acc0) rf[wr_addr0] <= wr_data0;
      if (acc1) rf[wr_addr1] <= wr_data1;
    end
  end

  // Saturating write counter, restarted when a clear begins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_start) begin
      cnt_q <= '0;
    end else if (cnt_sum[CNT_WIDTH]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= cnt_sum[CNT_WIDTH-1:0];
    end
  end

  assign wr_count = cnt_q;

  // Read ports: zero register first, then forwarding (port 1 over 0), then array.
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra      = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
      if (BYPASS_EN != 0) begin
        if (acc0 && (wr_addr0 == ra)) rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_data0;
        if (acc1 && (wr_addr1 == ra)) rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wr_data1;
      end
      if ((ZERO_REG_EN != 0) && (ra == '0)) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Debug view of the low 16 bits of the top register.
  if (DATA_WIDTH >= 16) begin : g_dbg_wide
    assign debug = rf[NUM_REGS-1][15:0];
  end else begin : g_dbg_narrow
    assign debug = {{(16-DATA_WIDTH){1'b0}}, rf[NUM_REGS-1]};
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three instances share one stimulus stream
// (default, no forwarding, 4-bit counter) and are compared against an
// array-based reference model.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wr_en0, wr_en1;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        clr_req;

  logic [63:0] rd_data, rd_data_nb, rd_data_sat;
  logic        clr_busy, clr_busy_nb, clr_busy_sat;
  logic [15:0] wr_count, wr_count_nb;
  logic [3:0]  wr_count_sat;
  logic [15:0] debug, debug_nb, debug_sat;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_rf [32];
  bit          m_busy;
  int          m_idx;
  int          m_cnt;

  register_file_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .clr_req(clr_req),
    .clr_busy(clr_busy), .wr_count(wr_count), .debug(debug)
  );

  register_file_mp #(.BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .clr_req(clr_req),
    .clr_busy(clr_busy_nb), .wr_count(wr_count_nb), .debug(debug_nb)
  );

  register_file_mp #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_sat),
    .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .clr_req(clr_req),
    .clr_busy(clr_busy_sat), .wr_count(wr_count_sat), .debug(debug_sat)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_busy = 1'b0;
    m_idx  = 0;
    m_cnt  = 0;
  endfunction

  // Expected read value for an index given the current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bp);
    if (!rst || a == 5'd0) return 32'h0;
    if (bp && !m_busy) begin
      if (wr_en1 && wr_addr1 == a) return wr_data1;
      if (wr_en0 && wr_addr0 == a) return wr_data0;
    end
    return m_rf[a];
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  function automatic void m_step();
    bit a0, a1;
    int n;
    if (!rst) begin
      m_reset();
      return;
    end
    if (m_busy) begin
      m_rf[m_idx] = '0;
      m_idx++;
      if (m_idx == 32) begin
        m_busy = 1'b0;
        m_idx  = 0;
      end
    end else begin
      a0 = wr_en0 && (wr_addr0 != 5'd0);
      a1 = wr_en1 && (wr_addr1 != 5'd0);
      if (a0) m_rf[wr_addr0] = wr_data0;
      if (a1) m_rf[wr_addr1] = wr_data1;
      n = (a0 && a1 && wr_addr0 == wr_addr1) ? 1 : int'(a0) + int'(a1);
      if (clr_req) begin
        m_busy = 1'b1;
        m_idx  = 0;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + n;
      end
    end
  endfunction

  function automatic int sat15(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  // Compare every observable output of all three instances against the model.
  task automatic check_all();
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      check("rd_bypass", {32'h0, rd_data[k*32 +: 32]}, {32'h0, exp_rd(a, 1'b1)});
      check("rd_nobypass", {32'h0, rd_data_nb[k*32 +: 32]}, {32'h0, exp_rd(a, 1'b0)});
      check("rd_sat", {32'h0, rd_data_sat[k*32 +: 32]}, {32'h0, exp_rd(a, 1'b1)});
    end
    check("wr_count", 64'(wr_count), 64'(m_cnt));
    check("wr_count_nb", 64'(wr_count_nb), 64'(m_cnt));
    check("wr_count_sat", 64'(wr_count_sat), 64'(sat15(m_cnt)));
    check("clr_busy", 64'(clr_busy), 64'(m_busy));
    check("clr_busy_nb", 64'(clr_busy_nb), 64'(m_busy));
    check("clr_busy_sat", 64'(clr_busy_sat), 64'(m_busy));
    check("debug", 64'(debug), 64'(m_rf[31][15:0]));
  endtask

  // One clock: inputs already driven after a falling edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic drive_wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
    wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
  endtask

  task automatic set_rd(input int k, input logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b0;
    rd_addr = '0;
    clr_req = 1'b0;
    drive_wr(0, 0, 0, 0, 0, 0);
    m_reset();

    // reset state
    @(negedge clk);
    @(negedge clk);
    set_rd(0, 5'd31);
    set_rd(1, 5'd5);
    #1;
    check("reset_rd", rd_data, 64'h0);
    check("reset_count", 64'(wr_count), 64'h0);
    check("reset_busy", 64'(clr_busy), 64'h0);
    check("reset_debug", 64'(debug), 64'h0);
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // basic write then read
    drive_wr(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    drive_wr(0, 0, 0, 0, 0, 0);
    set_rd(0, 5'd5);
    #1;
    check("basic_rd", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("basic_count", 64'(wr_count), 64'd1);
    cycle();

    // collision on index 7, then distinct indices 3 and 4
    drive_wr(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
    cycle();
    drive_wr(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    set_rd(0, 5'd7);
    set_rd(1, 5'd5);
    #1;
    check("collision_rd", 64'(rd_data[31:0]), 64'h22);
    check("collision_count", 64'(wr_count), 64'd2);
    cycle();
    drive_wr(0, 0, 0, 0, 0, 0);
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    #1;
    check("distinct_rd", rd_data, {32'h44, 32'h33});
    check("distinct_count", 64'(wr_count), 64'd4);
    cycle();

    // forwarding vs. no forwarding on index 9
    drive_wr(1, 5'd9, 32'hA5A5A5A5, 0, 0, 0);
    set_rd(1, 5'd9);
    #1;
    check("bypass_rd", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    check("nobypass_rd", 64'(rd_data_nb[63:32]), 64'h0);
    cycle();

    // zero register
    drive_wr(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    set_rd(0, 5'd0);
    #1;
    check("zero_bypass_rd", 64'(rd_data[31:0]), 64'h0);
    cycle();
    drive_wr(0, 0, 0, 0, 0, 0);
    #1;
    check("zero_rd", 64'(rd_data[31:0]), 64'h0);
    check("zero_count", 64'(wr_count), 64'd5);
    cycle();

    // randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      drive_wr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) wr_addr1 = wr_addr0;
      set_rd(0, 5'($urandom_range(0, 31)));
      set_rd(1, ($urandom_range(0, 1) == 0) ? wr_addr1 : 5'($urandom_range(0, 31)));
      clr_req = ($urandom_range(0, 59) == 0);
      cycle();
    end
    clr_req = 1'b0;
    drive_wr(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && m_busy; i++) cycle();
    #1;
    check("idle_before_clear", 64'(clr_busy), 64'h0);

    // fill, then clear with a write alongside the request and one mid-clear
    for (int i = 0; i < 16; i++) begin
      drive_wr(1, 5'(2*i), $urandom, 1, 5'(2*i+1), $urandom);
      cycle();
    end
    drive_wr(1, 5'd31, 32'h00001234, 0, 0, 0);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    #1;
    check("clear_debug_pre", 64'(debug), 64'h1234);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) drive_wr(1, 5'd6, 32'hCAFEF00D, 1, 5'd31, 32'h5555);
      else        drive_wr(0, 0, 0, 0, 0, 0);
      clr_req = (i == 8);
      #1;
      if (clr_busy) busy_cnt++;
      cycle();
    end
    clr_req = 1'b0;
    drive_wr(0, 0, 0, 0, 0, 0);
    check("clear_busy_cycles", 64'(busy_cnt), 64'd32);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(31 - a));
      #1;
      check("clear_rd", rd_data, 64'h0);
    end
    check("clear_count", 64'(wr_count), 64'h0);
    cycle();

    // counter saturation: 20 writes
    for (int i = 0; i < 10; i++) begin
      drive_wr(1, 5'(i + 1), $urandom, 1, 5'(i + 11), $urandom);
      cycle();
    end
    drive_wr(0, 0, 0, 0, 0, 0);
    #1;
    check("sat_count4", 64'(wr_count_sat), 64'd15);
    check("sat_count16", 64'(wr_count), 64'd20);
    cycle();

    // reset in the middle of a clear
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    #1;
    check("midclear_busy_before", 64'(clr_busy), 64'h1);
    rst = 1'b0;
    m_reset();
    #1;
    check("midclear_busy", 64'(clr_busy), 64'h0);
    check("midclear_busy_sat", 64'(clr_busy_sat), 64'h0);
    check("midclear_count", 64'(wr_count), 64'h0);
    check("midclear_debug", 64'(debug), 64'h0);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(a));
      #1;
      check("midclear_rd", rd_data, 64'h0);
      check("midclear_rd_nb", rd_data_nb, 64'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    #1;
    check("post_reset_busy", 64'(clr_busy), 64'h0);
    for (int i = 0; i < 20; i++) begin
      drive_wr($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom);
      set_rd(0, wr_addr0);
      set_rd(1, 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
